// File: rtl/div_unit_pkg.sv
// Shared CPU-wide definitions for the RV32M divider: operation encoding,
// FSM state encoding and small op-classification helpers.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // DIV and REM interpret operands as two's-complement numbers.
  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  // REM and REMU return the remainder; the others return the quotient.
  function automatic logic is_rem_op(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control and the divider.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The source holds valid and its payload stable until that edge; the sink
// may raise or drop ready at any time. in_* is the request channel
// (control -> divider), out_* is the response channel (divider -> control).
interface div_unit_if #(parameter int XLEN = div_unit_pkg::XLEN);

  logic                  in_valid;
  logic                  in_ready;
  div_unit_pkg::div_op_t op;
  logic [XLEN-1:0]       dividend;
  logic [XLEN-1:0]       divisor;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       result;

  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, busy, out_valid, result
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when that does not borrow.
module div_step #(
  parameter int XLEN = div_unit_pkg::XLEN
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Trial subtraction one bit wider than the remainder so the borrow is explicit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, dvs};
    q_bit   = ~diff[XLEN+1];
    rem_out = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU). Works on magnitudes, one
// quotient bit per cycle, and applies signs in a final fix-up cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = div_unit_pkg::XLEN
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus,
  output div_state_t dbg_state
);

  localparam int CW = $clog2(XLEN);

  div_state_t      state_q, state_d;
  div_op_t         op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;      // dividend bits shift out as quotient bits shift in
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   step_rem;
  logic            step_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[XLEN-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  logic            a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;

  // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    result_d  = result_q;

    a_neg   = is_signed_op(bus.op) & bus.dividend[XLEN-1];
    b_neg   = is_signed_op(bus.op) & bus.divisor[XLEN-1];
    a_mag   = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag   = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    div0    = (bus.divisor == '0);
    ovf     = is_signed_op(bus.op) && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
              && (bus.divisor == '1);
    quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = r_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          dvs_d   = b_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          cnt_d   = '0;
          // Special cases preload final values and skip straight to the
          // result register, keeping them to a two-edge latency.
          if (div0) begin
            special_d = 1'b1;
            quo_d     = '1;
            rem_d     = {1'b0, bus.dividend};
            state_d   = S_FIX;
          end else if (ovf) begin
            special_d = 1'b1;
            quo_d     = bus.dividend;
            rem_d     = '0;
            state_d   = S_FIX;
          end else begin
            special_d = 1'b0;
            quo_d     = a_mag;
            rem_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (special_q)
          result_d = is_rem_op(op_q) ? rem_q[XLEN-1:0] : quo_q;
        else
          result_d = is_rem_op(op_q) ? rem_fix : quo_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= DIV;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;

endmodule
